uart_rx_fifo: RTL and testbench



---
 rtl/uart_rx_fifo.sv | 228 ++++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: configurable-format serial receiver with 3-sample majority
// voting, start-glitch rejection, per-frame parity/framing flags and a
// first-word-fall-through output FIFO with a valid/ready handshake.
module uart_rx_fifo #(
  parameter int DIVISOR    = 868,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n_in,
  input  logic                          line_in,
  output logic [DATA_BITS-1:0]          data_out,
  output logic                          parity_err_out,
  output logic                          frame_err_out,
  output logic                          valid_out,
  input  logic                          ready_in,
  output logic                          overrun_out,
  output logic [$clog2(FIFO_DEPTH):0]   count_out
);

  localparam int CNT_W = $clog2(DIVISOR);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;
  localparam int EW    = DATA_BITS + 2;

  localparam logic [CNT_W-1:0] SMP0  = CNT_W'(DIVISOR / 2 - 1);
  localparam logic [CNT_W-1:0] SMP1  = CNT_W'(DIVISOR / 2);
  localparam logic [CNT_W-1:0] SMP2  = CNT_W'(DIVISOR / 2 + 1);
  localparam logic [CNT_W-1:0] CLAST = CNT_W'(DIVISOR - 1);
  localparam logic [IDX_W-1:0] ILAST = IDX_W'(DATA_BITS - 1);
  localparam logic [CW-1:0]    FULLC = CW'(FIFO_DEPTH);
  localparam logic             LAST_STOP = (STOP_BITS == 2) ? 1'b1 : 1'b0;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_PUSH
  } state_t;

  logic                 rst_n_sync;
  logic [1:0]           rst_sync_q;
  logic [1:0]           sync_q;
  logic                 ls;
  logic                 ls_last_q;
  logic                 smp0_q, smp1_q;
  logic                 maj;
  logic                 at_mid, at_wrap;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 stop_q, stop_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 push;

  logic [EW-1:0]        mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_q, rd_q;
  logic [CW-1:0]        count_q, count_d;
  logic [EW-1:0]        last_q;
  logic                 ovr_q;
  logic                 pop, full, wr_en;
  logic [EW-1:0]        head;

  // Reset: asserts asynchronously, releases two clocks after rst_n_in rises.
  always_ff @(posedge clk or negedge rst_n_in) begin
    if (!rst_n_in) rst_sync_q <= 2'b00;
    else           rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n_sync = rst_sync_q[1];

  // Line synchroniser and edge history; preset high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      sync_q    <= 2'b11;
      ls_last_q <= 1'b1;
      smp0_q    <= 1'b1;
      smp1_q    <= 1'b1;
    end else begin
      sync_q    <= {sync_q[0], line_in};
      ls_last_q <= sync_q[1];
      if (cnt_q == SMP0) smp0_q <= sync_q[1];
      if (cnt_q == SMP1) smp1_q <= sync_q[1];
    end
  end

  assign ls      = sync_q[1];
  assign maj     = (smp0_q & smp1_q) | (smp0_q & ls) | (smp1_q & ls);
  assign at_mid  = (cnt_q == SMP2);
  assign at_wrap = (cnt_q == CLAST);

  // Receiver FSM state and frame-assembly registers.
  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      stop_q  <= 1'b0;
      shift_q <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      stop_q  <= stop_d;
      shift_q <= shift_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
    end
  end

  // Next-state logic: bit timing, majority sampling and frame-error detection.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    push    = 1'b0;
    if (state_q != S_IDLE && state_q != S_PUSH) begin
      cnt_d = at_wrap ? '0 : cnt_q + 1'b1;
    end
    case (state_q)
      S_IDLE: begin
        // Only a high-to-low transition starts a frame, so a held-low
        // line (break) produces a single frame and then waits.
        if (ls_last_q && !ls) begin
          state_d = S_START;
          cnt_d   = '0;
          shift_d = '0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
        end
      end
      S_START: begin
        if (at_mid && maj) begin
          state_d = S_IDLE;
        end else if (at_wrap) begin
          state_d = S_DATA;
          idx_d   = '0;
        end
      end
      S_DATA: begin
        if (at_mid) shift_d[idx_q] = maj;
        if (at_wrap) begin
          if (idx_q == ILAST) begin
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
            stop_d  = 1'b0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (at_mid) begin
          perr_d = (PARITY == 1) ? ~((^shift_q) ^ maj) : ((^shift_q) ^ maj);
        end
        if (at_wrap) begin
          state_d = S_STOP;
          stop_d  = 1'b0;
        end
      end
      S_STOP: begin
        // The last stop bit hands off to PUSH right after its third sample.
        if (at_mid) begin
          if (!maj) ferr_d = 1'b1;
          if (stop_q == LAST_STOP) state_d = S_PUSH;
        end
        if (at_wrap) stop_d = 1'b1;
      end
      S_PUSH: begin
        push    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign valid_out = (count_q != '0);
  assign pop       = valid_out & ready_in;
  assign full      = (count_q == FULLC);
  assign wr_en     = push & (~full | pop);

  // FIFO storage; contents are qualified by count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q] <= {shift_q, perr_q, ferr_q};
  end

  // FIFO occupancy update for push, pop or both.
  always_comb begin
    count_d = count_q;
    if (wr_en && !pop)      count_d = count_q + 1'b1;
    else if (!wr_en && pop) count_d = count_q - 1'b1;
  end

  // FIFO pointers, count, overrun pulse and the hold-last-popped register.
  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      last_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovr_q   <= push & full & ~pop;
      if (wr_en) wr_q <= wr_q + 1'b1;
      if (pop) begin
        rd_q   <= rd_q + 1'b1;
        last_q <= mem_q[rd_q];
      end
    end
  end

  // When empty, the outputs keep showing the most recently popped entry.
  assign head           = valid_out ? mem_q[rd_q] : last_q;
  assign data_out       = head[EW-1:2];
  assign parity_err_out = head[1];
  assign frame_err_out  = head[0];
  assign overrun_out    = ovr_q;
  assign count_out      = count_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed table-driven bench for uart_rx_fifo using three
// frame formats (8N1, 8E1, 9N2), all at 16 clocks per bit.
module tb_uart_rx_fifo;

  localparam int DIV = 16;

  logic clk = 1'b0;
  logic rst_n_ab, rst_n_c;
  logic line_a, line_b, line_c;
  logic rdy_a, rdy_b, rdy_c;

  logic [7:0] d_a, d_b;
  logic [8:0] d_c;
  logic pe_a, fe_a, v_a, ov_a;
  logic pe_b, fe_b, v_b, ov_b;
  logic pe_c, fe_c, v_c, ov_c;
  logic [2:0] cnt_a, cnt_b, cnt_c;

  int n_vec = 0;
  int n_err = 0;
  int ovc_a = 0, ovc_b = 0, ovc_c = 0;
  logic [10:0] q_a[$], q_b[$], q_c[$];

  always #5 clk = ~clk;

  uart_rx_fifo #(.DIVISOR(DIV), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
    .clk(clk), .rst_n_in(rst_n_ab), .line_in(line_a), .data_out(d_a),
    .parity_err_out(pe_a), .frame_err_out(fe_a), .valid_out(v_a),
    .ready_in(rdy_a), .overrun_out(ov_a), .count_out(cnt_a));

  uart_rx_fifo #(.DIVISOR(DIV), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_b (
    .clk(clk), .rst_n_in(rst_n_ab), .line_in(line_b), .data_out(d_b),
    .parity_err_out(pe_b), .frame_err_out(fe_b), .valid_out(v_b),
    .ready_in(rdy_b), .overrun_out(ov_b), .count_out(cnt_b));

  uart_rx_fifo #(.DIVISOR(DIV), .DATA_BITS(9), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_c (
    .clk(clk), .rst_n_in(rst_n_c), .line_in(line_c), .data_out(d_c),
    .parity_err_out(pe_c), .frame_err_out(fe_c), .valid_out(v_c),
    .ready_in(rdy_c), .overrun_out(ov_c), .count_out(cnt_c));

  // Capture every accepted beat and every overrun cycle, away from the active edge.
  always @(negedge clk) begin
    if (v_a && rdy_a) q_a.push_back({1'b0, d_a, pe_a, fe_a});
    if (v_b && rdy_b) q_b.push_back({1'b0, d_b, pe_b, fe_b});
    if (v_c && rdy_c) q_c.push_back({d_c, pe_c, fe_c});
    if (ov_a) ovc_a++;
    if (ov_b) ovc_b++;
    if (ov_c) ovc_c++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int         sel;     // 0 = 8N1, 1 = 8E1, 2 = 9N2
    logic [8:0] din;
    int         par;     // parity bit to drive, -1 = none
    logic       stp;     // stop bit level
    logic [8:0] exp_d;
    logic       exp_pe;
    logic       exp_fe;
  } vec_t;

  vec_t vecs[8];

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input int sel, input logic v);
    case (sel)
      0:       line_a = v;
      1:       line_b = v;
      default: line_c = v;
    endcase
  endtask

  // Sends one frame on the selected line; limit truncates it after that many bits.
  task automatic send_frame(input int sel, input logic [8:0] d, input int par,
                            input logic stp, input int limit);
    logic bits[16];
    int   n, nd, ns;
    nd = (sel == 2) ? 9 : 8;
    ns = (sel == 2) ? 2 : 1;
    bits[0] = 1'b0;
    n = 1;
    for (int i = 0; i < nd; i++) begin bits[n] = d[i]; n++; end
    if (par >= 0) begin bits[n] = par[0]; n++; end
    for (int i = 0; i < ns; i++) begin bits[n] = stp; n++; end
    drive(sel, 1'b1);
    wait_cyc(2 * DIV);
    for (int i = 0; i < n && i < limit; i++) begin
      drive(sel, bits[i]);
      wait_cyc(DIV);
    end
    if (limit >= n) drive(sel, 1'b1);
  endtask

  task automatic get_beat(input int sel, input int idx, output logic [10:0] e, output int sz);
    e = '0;
    case (sel)
      0:       begin sz = q_a.size(); if (idx < sz) e = q_a[idx]; end
      1:       begin sz = q_b.size(); if (idx < sz) e = q_b[idx]; end
      default: begin sz = q_c.size(); if (idx < sz) e = q_c[idx]; end
    endcase
  endtask

  initial begin
    logic [10:0] e;
    int sz;

    vecs[0] = '{0, 9'h0A5, -1, 1'b1, 9'h0A5, 1'b0, 1'b0};
    vecs[1] = '{1, 9'h007,  1, 1'b1, 9'h007, 1'b0, 1'b0};
    vecs[2] = '{1, 9'h007,  0, 1'b1, 9'h007, 1'b1, 1'b0};
    vecs[3] = '{0, 9'h03C, -1, 1'b0, 9'h03C, 1'b0, 1'b1};
    vecs[4] = '{0, 9'h011, -1, 1'b1, 9'h011, 1'b0, 1'b0};
    vecs[5] = '{1, 9'h080,  1, 1'b1, 9'h080, 1'b0, 1'b0};
    vecs[6] = '{1, 9'h0C3,  1, 1'b0, 9'h0C3, 1'b1, 1'b1};
    vecs[7] = '{0, 9'h0FF, -1, 1'b1, 9'h0FF, 1'b0, 1'b0};

    line_a = 1'b1; line_b = 1'b1; line_c = 1'b1;
    rdy_a = 1'b1; rdy_b = 1'b1; rdy_c = 1'b1;
    rst_n_ab = 1'b0; rst_n_c = 1'b0;
    wait_cyc(4);

    // Reset state
    check("rst_valid", {31'b0, v_a}, 32'h0);
    check("rst_count", {29'b0, cnt_a}, 32'h0);
    check("rst_data", {24'b0, d_a}, 32'h0);
    check("rst_flags", {30'b0, pe_a, fe_a}, 32'h0);
    check("rst_overrun", {31'b0, ov_a}, 32'h0);
    rst_n_ab = 1'b1; rst_n_c = 1'b1;
    wait_cyc(4);

    // Table-driven single frames
    for (int k = 0; k < 8; k++) begin
      q_a.delete(); q_b.delete(); q_c.delete();
      send_frame(vecs[k].sel, vecs[k].din, vecs[k].par, vecs[k].stp, 99);
      wait_cyc(40);
      get_beat(vecs[k].sel, 0, e, sz);
      check($sformatf("v%0d_beats", k), sz, 1);
      check($sformatf("v%0d_data", k), {23'b0, e[10:2]}, {23'b0, vecs[k].exp_d});
      check($sformatf("v%0d_perr", k), {31'b0, e[1]}, {31'b0, vecs[k].exp_pe});
      check($sformatf("v%0d_ferr", k), {31'b0, e[0]}, {31'b0, vecs[k].exp_fe});
    end
    check("no_overrun_a", ovc_a, 0);
    check("no_overrun_b", ovc_b, 0);

    // Start glitch rejected, then a genuine frame
    q_a.delete();
    line_a = 1'b0; wait_cyc(4); line_a = 1'b1;
    wait_cyc(3 * DIV);
    check("glitch_beats", q_a.size(), 0);
    check("glitch_count", {29'b0, cnt_a}, 32'h0);
    send_frame(0, 9'h05A, -1, 1'b1, 99);
    wait_cyc(40);
    get_beat(0, 0, e, sz);
    check("after_glitch_beats", sz, 1);
    check("after_glitch_data", {23'b0, e[10:2]}, 32'h05A);

    // Break: line held low gives one all-zero frame with frame error
    q_a.delete();
    line_a = 1'b0; wait_cyc(14 * DIV); line_a = 1'b1;
    wait_cyc(40);
    get_beat(0, 0, e, sz);
    check("break_beats", sz, 1);
    check("break_entry", {21'b0, e}, 32'h001);

    // FIFO fill and overrun with the consumer stalled
    q_a.delete();
    ovc_a = 0;
    rdy_a = 1'b0;
    for (int k = 1; k <= 4; k++) send_frame(0, 9'(k), -1, 1'b1, 99);
    wait_cyc(40);
    check("fill_count4", {29'b0, cnt_a}, 32'h4);
    check("fill_overrun_none", ovc_a, 0);
    send_frame(0, 9'h005, -1, 1'b1, 99);
    wait_cyc(40);
    check("ovr_count", {29'b0, cnt_a}, 32'h4);
    check("ovr_pulses", ovc_a, 1);
    check("ovr_head", {24'b0, d_a}, 32'h01);
    rdy_a = 1'b1;
    wait_cyc(10);
    check("drain_beats", q_a.size(), 4);
    for (int k = 0; k < 4; k++) begin
      get_beat(0, k, e, sz);
      check($sformatf("drain_%0d", k), {21'b0, e}, {21'b0, 1'b0, 8'(k + 1), 2'b00});
    end
    check("drain_count", {29'b0, cnt_a}, 32'h0);
    check("drain_valid", {31'b0, v_a}, 32'h0);

    // 9-bit, two stop bits; reset mid-frame discards the partial frame
    q_c.delete();
    send_frame(2, 9'h1FF, -1, 1'b1, 99);
    wait_cyc(40);
    get_beat(2, 0, e, sz);
    check("c_beats", sz, 1);
    check("c_entry", {21'b0, e}, {21'b0, 9'h1FF, 2'b00});
    check("c_hold_last", {23'b0, d_c}, 32'h1FF);
    q_c.delete();
    send_frame(2, 9'h0AA, -1, 1'b1, 6);
    rst_n_c = 1'b0;
    #1;
    check("c_rst_data", {23'b0, d_c}, 32'h0);
    check("c_rst_valid", {31'b0, v_c}, 32'h0);
    check("c_rst_count", {29'b0, cnt_c}, 32'h0);
    line_c = 1'b1;
    wait_cyc(5);
    rst_n_c = 1'b1;
    wait_cyc(12 * DIV);
    check("c_no_spurious", q_c.size(), 0);
    check("c_no_spurious_cnt", {29'b0, cnt_c}, 32'h0);
    send_frame(2, 9'h155, -1, 1'b1, 99);
    wait_cyc(40);
    get_beat(2, 0, e, sz);
    check("c2_beats", sz, 1);
    check("c2_entry", {21'b0, e}, {21'b0, 9'h155, 2'b00});
    check("c_no_overrun", ovc_c, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
